// File: rtl/timer_controller.sv
// Countdown timer: prescaled one-second tick, pause/resume, cancel and a timed alarm phase.
// All outputs are registered; state, prescaler and edge detectors share one clocked process.
module timer_controller #(
    parameter int unsigned DIV        = 50_000_000,
    parameter int unsigned CNT_W      = 26,
    parameter int unsigned TIME_W     = 12,
    parameter int unsigned ALARM_SECS = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              load,
    input  logic [TIME_W-1:0] preset,
    output logic              is_counting,
    output logic              sec_clk,
    output logic [TIME_W-1:0] remaining,
    output logic              alarm
);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StAlarm} state_e;

    localparam logic [CNT_W-1:0]  PresMax   = CNT_W'(DIV - 1);
    localparam logic [TIME_W-1:0] AlarmLast = TIME_W'(ALARM_SECS - 1);
    localparam logic [TIME_W-1:0] OneSec    = TIME_W'(1);

    state_e            state_q;
    logic [CNT_W-1:0]  prescaler_q;
    logic [TIME_W-1:0] alarm_secs_q;
    logic              start_q;
    logic              stop_q;

    logic start_edge;
    logic stop_edge;
    logic sec_done;

    assign start_edge = start & ~start_q;
    assign stop_edge  = stop & ~stop_q;
    assign sec_done   = (prescaler_q == PresMax);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            prescaler_q  <= '0;
            alarm_secs_q <= '0;
            remaining    <= '0;
            is_counting  <= 1'b0;
            sec_clk      <= 1'b0;
            alarm        <= 1'b0;
            // Held-high inputs at reset release must not look like edges
            start_q      <= 1'b1;
            stop_q       <= 1'b1;
        end else begin
            start_q <= start;
            stop_q  <= stop;
            sec_clk <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        remaining <= preset;
                    end else if (start_edge && !stop_edge && remaining != '0) begin
                        state_q     <= StRun;
                        prescaler_q <= '0;
                        is_counting <= 1'b1;
                    end
                end
                StRun: begin
                    if (stop_edge) begin
                        state_q     <= StIdle;
                        prescaler_q <= '0;
                        remaining   <= '0;
                        is_counting <= 1'b0;
                    end else begin
                        // The prescaler keeps counting on the pause edge itself
                        if (sec_done) begin
                            prescaler_q <= '0;
                            sec_clk     <= 1'b1;
                            remaining   <= remaining - OneSec;
                        end else begin
                            prescaler_q <= prescaler_q + 1'b1;
                        end
                        if (sec_done && remaining == OneSec) begin
                            state_q      <= StAlarm;
                            alarm_secs_q <= '0;
                            is_counting  <= 1'b0;
                            alarm        <= 1'b1;
                        end else if (start_edge) begin
                            state_q     <= StPause;
                            is_counting <= 1'b0;
                        end
                    end
                end
                StPause: begin
                    if (stop_edge) begin
                        state_q     <= StIdle;
                        prescaler_q <= '0;
                        remaining   <= '0;
                    end else if (start_edge) begin
                        state_q     <= StRun;
                        is_counting <= 1'b1;
                    end
                end
                StAlarm: begin
                    if (start_edge || stop_edge) begin
                        state_q     <= StIdle;
                        prescaler_q <= '0;
                        alarm       <= 1'b0;
                    end else if (sec_done) begin
                        prescaler_q <= '0;
                        if (alarm_secs_q == AlarmLast) begin
                            state_q <= StIdle;
                            alarm   <= 1'b0;
                        end else begin
                            alarm_secs_q <= alarm_secs_q + 1'b1;
                        end
                    end else begin
                        prescaler_q <= prescaler_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/timer_controller.md
# timer_controller

Parametrised successor of the egg-timer control FSM. Turns a programmable seconds preset into a countdown with a prescaled one-second tick, adds pause/resume, cancel and a timed alarm phase. Sits between the front-panel inputs (already debounced) and the display/beeper. Drives the `sec_clk` tick and the `remaining` value that the display path consumes.

## Interface
- `DIV`, default 50_000_000: clock cycles per second. Must be ≥ 2.
- `CNT_W`, default 26: prescaler width. 2^CNT_W ≥ DIV.
- `TIME_W`, default 12: width of the seconds count.
- `ALARM_SECS`, default 10: alarm duration in seconds. Range 1..2^TIME_W−1.

- `clk` in 1: single clock. All state changes on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: level input. Rising edge starts, pauses or resumes the countdown.
- `stop` in 1: level input. Rising edge cancels the countdown or silences the alarm.
- `load` in 1: in IDLE, loads `preset` into `remaining`.
- `preset` in TIME_W: countdown length in seconds.
- `is_counting` out 1: high in RUN only.
- `sec_clk` out 1: one-cycle pulse per elapsed second in RUN.
- `remaining` out TIME_W: seconds left.
- `alarm` out 1: high in ALARM only.

## Operation
- **Edge detect.** Registered copies `start_q` and `stop_q` reset to 1, so an input already held high at reset release is not an edge. An edge is the input at 1 while its `_q` copy is 0. A held input produces exactly one edge.
- **States.** IDLE, RUN, PAUSE, ALARM. Encoding is free. All outputs are registered.
- **IDLE**
  - `load`: `remaining <= preset`. A start edge in the same cycle is ignored.
  - Start edge with `remaining ≠ 0`: go to RUN, prescaler cleared to 0.
  - Start edge with `remaining = 0`: ignored.
- **RUN**
  - Prescaler increments every cycle.
  - When it is at DIV−1, the next edge does all of: prescaler <= 0, `sec_clk <= 1` for one cycle, `remaining <= remaining−1`.
  - If that decrement takes `remaining` from 1 to 0: go to ALARM, prescaler cleared.
  - Start edge: go to PAUSE.
  - Stop edge: go to IDLE with `remaining <= 0`.
- **PAUSE**
  - Prescaler and `remaining` frozen.
  - Start edge: back to RUN, prescaler resumes from its held value (not cleared).
  - Stop edge: go to IDLE with `remaining <= 0`.
- **ALARM**
  - `alarm` = 1. Prescaler runs and counts ALARM_SECS whole seconds.
  - No `sec_clk` pulses; `remaining` stays 0.
  - After ALARM_SECS·DIV cycles, or on any start or stop edge: go to IDLE.
- **Priority.** Stop edge beats start edge in the same cycle. `load` is ignored outside IDLE.
- **Arithmetic.** `remaining` never wraps below 0. The prescaler never exceeds DIV−1.
- **Reset** (`rst` = 0 at a clock edge) forces, from any state including mid-second:
  - state IDLE, prescaler 0, `remaining` 0
  - `is_counting`, `sec_clk`, `alarm` all 0
  - `start_q`, `stop_q` 1

## Timing
- **Start.** Start edge sampled at clock edge N: `is_counting` = 1 after edge N. First `sec_clk` pulse and first decrement after edge N+DIV. Later pulses every DIV cycles.
- **Pulse width.** `sec_clk` is high for exactly one cycle and never in two consecutive cycles (DIV ≥ 2).
- **Run length.** Preset P: RUN lasts exactly P·DIV cycles. `alarm` rises on the same edge as the final `sec_clk` pulse and the 1→0 decrement, and `is_counting` falls on that edge.
- **Alarm length.** `alarm` lasts ALARM_SECS·DIV cycles unless silenced. Silencing edge at M: `alarm` = 0 after M.
- **Pause accuracy.** Pausing with prescaler at k and resuming at edge R: next `sec_clk` after edge R+(DIV−k).
- **Cancel.** Stop edge at M: `is_counting` = 0 and `remaining` = 0 after M. No `sec_clk` after M.
- **Latency.** All input-to-output latencies are one clock.

## Test plan
Use DIV=4, TIME_W=4, ALARM_SECS=2.
- **Reset.** Hold `rst`=0 for 2 cycles with `start`=1 → all outputs 0. Releasing `rst` with `start` still high → no RUN entry.
- **Full countdown.** `load` with `preset`=3, then `start` high for 5 cycles.
  - Exactly one RUN entry.
  - `sec_clk` pulses 4, 8, 12 cycles after the start edge.
  - `remaining` steps 3→2→1→0.
  - `alarm` high for 8 cycles, then IDLE with all outputs 0.
- **Pause/resume.** `preset`=3. Start edge, then second start edge 6 cycles later (`remaining`=2, prescaler=2).
  - While paused for 10 cycles: `remaining` stays 2, no `sec_clk`.
  - Resume edge → next `sec_clk` 2 cycles later.
- **Cancel and zero start.** Stop edge 5 cycles into RUN → IDLE, `remaining`=0, no further `sec_clk`. A following start edge → stays IDLE.
- **Simultaneous and alarm silence.**
  - In RUN, start and stop rising together → IDLE, `remaining`=0.
  - In ALARM, a start edge → `alarm`=0 on the next cycle, state IDLE.
- **Reset mid-second.** In RUN with prescaler=2, drive `rst`=0 for one cycle → all outputs 0 on the next cycle and no `sec_clk` pulse.
